// File: rtl/seqgen_pkg.sv
// Shared constants and helpers for the one-hot phase sequencer family.
package seqgen_pkg;

  localparam int unsigned MAX_PH = 16;

  localparam logic MODE_RING     = 1'b0;
  localparam logic MODE_PINGPONG = 1'b1;
  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;

  // Phase idx maps to bit (n-1-idx); out-of-range requests yield all-zero.
  function automatic logic [MAX_PH-1:0] onehot_of(input int unsigned idx, input int unsigned n);
    logic [MAX_PH-1:0] r;
    r = '0;
    if (idx < n && n <= MAX_PH) r = MAX_PH'(1) << (n - 1 - idx);
    return r;
  endfunction

  function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (n - 1) : idx;
  endfunction

endpackage

// File: rtl/seqgen_prescaler.sv
// Step-rate prescaler: one step every div+1 enabled cycles, synchronous clear.
module seqgen_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             sclr,
  output logic             step_c
);

  logic [DIV_W-1:0] cnt;

  // >= so that lowering div below a running count steps right away
  assign step_c = en && (cnt >= div);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)          cnt <= '0;
    else if (sclr)     cnt <= '0;
    else if (step_c)   cnt <= '0;
    else if (en)       cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/phase_seq_gen.sv
// N-phase one-hot sequencer (ring up/down or ping-pong) with registered outputs.
// Optional dead time between phases when SEQGEN_DEADTIME_EN is defined.
module phase_seq_gen
  import seqgen_pkg::*;
#(
  parameter int unsigned N_PH   = 4,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned DEAD_W = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    dir,
  input  logic [DIV_W-1:0]        div,
  input  logic                    load,
  input  logic [$clog2(N_PH)-1:0] load_idx,
`ifdef SEQGEN_DEADTIME_EN
  input  logic [DEAD_W-1:0]       dead,
`endif
  output logic [N_PH-1:0]         out,
  output logic [$clog2(N_PH)-1:0] idx,
  output logic                    tick,
  output logic                    wrap
);

  localparam int unsigned IDX_W = $clog2(N_PH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PH - 1);
  localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(N_PH - 2);
  localparam logic [N_PH-1:0]  OUT_RST  = N_PH'(onehot_of(0, N_PH));

  if (N_PH < 2 || N_PH > MAX_PH || DEAD_W == 0) begin : g_param_err
    $error("phase_seq_gen: unsupported parameter values");
  end

  logic             step_c;
  logic             pdir, pdir_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             tick_nxt, wrap_nxt;
  logic [N_PH-1:0]  out_nxt, phase_oh;

  seqgen_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .div    (div),
    .sclr   (load),
    .step_c (step_c)
  );

  // Phase index / ping-pong direction next state; load outranks a step.
  always_comb begin
    idx_nxt  = idx;
    pdir_nxt = pdir;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (load) begin
      idx_nxt  = IDX_W'(clamp_idx(32'(load_idx), N_PH));
      pdir_nxt = DIR_UP;
    end else if (step_c) begin
      tick_nxt = 1'b1;
      if (mode == MODE_RING) begin
        if (dir == DIR_UP) begin
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          if (idx == '0) begin
            idx_nxt  = IDX_LAST;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end else begin
        if (pdir == DIR_UP) begin
          if (idx == IDX_LAST) begin
            idx_nxt  = IDX_PEN;
            pdir_nxt = DIR_DOWN;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          if (idx == '0) begin
            idx_nxt  = IDX_W'(1);
            pdir_nxt = DIR_UP;
            wrap_nxt = 1'b1;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
    end
  end

  assign phase_oh = N_PH'(onehot_of(32'(idx_nxt), N_PH));

`ifdef SEQGEN_DEADTIME_EN
  logic [DEAD_W-1:0] dead_cnt, dead_nxt;

  // Blank the output for `dead` enabled cycles after every step.
  always_comb begin
    dead_nxt = dead_cnt;
    out_nxt  = out;
    if (load) begin
      dead_nxt = '0;
      out_nxt  = phase_oh;
    end else if (step_c) begin
      dead_nxt = dead;
      out_nxt  = (dead == '0) ? phase_oh : '0;
    end else if (en && dead_cnt != '0) begin
      dead_nxt = dead_cnt - DEAD_W'(1);
      out_nxt  = (dead_cnt == DEAD_W'(1)) ? phase_oh : '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) dead_cnt <= '0;
    else      dead_cnt <= dead_nxt;
  end
`else
  always_comb begin
    out_nxt = phase_oh;
  end
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      idx  <= '0;
      pdir <= DIR_UP;
      out  <= OUT_RST;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      pdir <= pdir_nxt;
      out  <= out_nxt;
      tick <= tick_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_phase_seq_gen.sv
// Scoreboard bench for phase_seq_gen with a 4-phase and a 5-phase instance.
// Dead-time scenario is included when SEQGEN_DEADTIME_EN is defined.
module tb_phase_seq_gen;

  typedef struct packed {
    logic [2:0] idx;
    logic [4:0] out;
    logic       tick;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0, mode = 1'b0, dir = 1'b0, load = 1'b0;
  logic [7:0] div = '0;
  logic [1:0] load_idx = '0;
  logic [2:0] load_idx5 = '0;
`ifdef SEQGEN_DEADTIME_EN
  logic [3:0] dead = '0;
`endif

  logic [3:0] out4;
  logic [1:0] idx4;
  logic       tick4, wrap4;
  logic [4:0] out5;
  logic [2:0] idx5;
  logic       tick5, wrap5;

  exp_t sb4[$];
  exp_t sb5[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   m_idx[2];
  int   m_pd[2];
  int   m_cnt[2];

  always #5 clk = ~clk;

  phase_seq_gen #(.N_PH(4), .DIV_W(8), .DEAD_W(4)) dut4 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .dir(dir), .div(div),
    .load(load), .load_idx(load_idx),
`ifdef SEQGEN_DEADTIME_EN
    .dead(dead),
`endif
    .out(out4), .idx(idx4), .tick(tick4), .wrap(wrap4)
  );

  phase_seq_gen #(.N_PH(5), .DIV_W(8), .DEAD_W(4)) dut5 (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .dir(dir), .div(div),
    .load(load), .load_idx(load_idx5),
`ifdef SEQGEN_DEADTIME_EN
    .dead(dead),
`endif
    .out(out5), .idx(idx5), .tick(tick5), .wrap(wrap5)
  );

  function automatic exp_t mk(int unsigned n, int unsigned i, bit t, bit w);
    exp_t r;
    r.idx  = 3'(i);
    r.out  = 5'(32'd1 << (n - 1 - i));
    r.tick = t;
    r.wrap = w;
    return r;
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) clr = 1'b1;
      sb4.push_back(mk(4, 0, 0, 0));
      sb5.push_back(mk(5, 0, 0, 0));
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
      e = sb5.pop_front();
      o = {idx5, out5, tick5, wrap5};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset c=%0d dut5: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
  endtask

  task automatic test_ring_up();
    int         ei[4]  = '{1, 2, 3, 0};
    logic [4:0] eo[4]  = '{5'b00100, 5'b00010, 5'b00001, 5'b01000};
    bit         ew[4]  = '{0, 0, 0, 1};
    exp_t e, o;
    div = 8'd0; mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e.idx = 3'(ei[c]); e.out = eo[c]; e.tick = 1'b1; e.wrap = ew[c];
      sb4.push_back(e);
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ring_up c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_ring_down_div();
    exp_t e, o;
    int   k;
    div = 8'd3; dir = 1'b1; mode = 1'b0; en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      k = (c + 1) / 4;
      sb4.push_back(mk(4, (4 - k) % 4, (c % 4) == 3, c == 3));
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL ring_down_div c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_pingpong();
    int p4i[11] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2};
    bit p4w[11] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int p5i[11] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    bit p5w[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    exp_t e, o;
    mode = 1'b1; div = 8'd0;
    for (int c = 0; c < 11; c++) begin
      load = (c == 0); load_idx = 2'd0; load_idx5 = 3'd0; en = (c != 0);
      sb4.push_back(mk(4, p4i[c], c != 0, p4w[c]));
      sb5.push_back(mk(5, p5i[c], c != 0, p5w[c]));
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pingpong c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
      e = sb5.pop_front();
      o = {idx5, out5, tick5, wrap5};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL pingpong c=%0d dut5: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    load = 1'b0; en = 1'b0; mode = 1'b0;
  endtask

  // Pause mid-period, then lower div below the running count.
  task automatic test_en_hold();
    exp_t e, o;
    int   ei;
    bit   et;
    mode = 1'b0; dir = 1'b0;
    for (int c = 0; c < 23; c++) begin
      load = (c == 0); load_idx = 2'd0;
      en   = (c >= 1 && c <= 3) || (c >= 14);
      div  = (c >= 20) ? 8'd1 : 8'd5;
      ei   = (c < 16) ? 0 : (c < 20) ? 1 : (c < 22) ? 2 : 3;
      et   = (c == 16) || (c == 20) || (c == 22);
      sb4.push_back(mk(4, ei, et, 0));
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL en_hold c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  // Load vs step priority, clamping, load while disabled, pdir reset by load.
  task automatic test_load();
    bit ld[14]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    bit ens[14] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};
    int li4[14] = '{0, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int li5[14] = '{0, 0, 7, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int e4i[14] = '{0, 1, 2, 3, 3, 3, 0, 1, 2, 3, 2, 1, 2, 2};
    bit e4w[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int e5i[14] = '{0, 1, 4, 0, 4, 4, 0, 1, 2, 3, 4, 1, 2, 2};
    bit e5w[14] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    bit et[14]  = '{0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1, 0};
    exp_t e, o;
    div = 8'd0; dir = 1'b0;
    for (int c = 0; c < 14; c++) begin
      load = ld[c]; en = ens[c];
      load_idx = 2'(li4[c]); load_idx5 = 3'(li5[c]);
      mode = (c >= 7 && c <= 12);
      sb4.push_back(mk(4, e4i[c], et[c], e4w[c]));
      sb5.push_back(mk(5, e5i[c], et[c], e5w[c]));
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
      e = sb5.pop_front();
      o = {idx5, out5, tick5, wrap5};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL load c=%0d dut5: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    load = 1'b0; en = 1'b0; mode = 1'b0;
  endtask

  // Random traffic against a behavioural reference for both instances.
  task automatic test_random();
    exp_t e, o;
    int   n, li;
    bit   t, w;
    for (int c = 0; c < 400; c++) begin
      load      = (c == 0) || ($urandom_range(0, 24) == 0);
      en        = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 14) == 0) dir = ~dir;
      div       = 8'($urandom_range(0, 3));
      load_idx  = 2'($urandom_range(0, 3));
      load_idx5 = 3'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) begin
        n = (k == 0) ? 4 : 5;
        li = (k == 0) ? int'(load_idx) : int'(load_idx5);
        t = 0; w = 0;
        if (load) begin
          m_idx[k] = (li > n - 1) ? n - 1 : li;
          m_cnt[k] = 0;
          m_pd[k]  = 0;
        end else if (en) begin
          if (m_cnt[k] >= int'(div)) begin
            m_cnt[k] = 0;
            t = 1;
            if (!mode) begin
              if (!dir) begin
                m_idx[k] = (m_idx[k] + 1) % n;
                w = (m_idx[k] == 0);
              end else begin
                w = (m_idx[k] == 0);
                m_idx[k] = (m_idx[k] + n - 1) % n;
              end
            end else if (m_pd[k] == 0) begin
              if (m_idx[k] == n - 1) begin m_pd[k] = 1; m_idx[k] = n - 2; w = 1; end
              else m_idx[k] = m_idx[k] + 1;
            end else begin
              if (m_idx[k] == 0) begin m_pd[k] = 0; m_idx[k] = 1; w = 1; end
              else m_idx[k] = m_idx[k] - 1;
            end
          end else begin
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
        if (k == 0) sb4.push_back(mk(n, m_idx[k], t, w));
        else        sb5.push_back(mk(n, m_idx[k], t, w));
      end
      clk_edge();
      e = sb4.pop_front();
      o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
      e = sb5.pop_front();
      o = {idx5, out5, tick5, wrap5};
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL random c=%0d dut5: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    load = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
  endtask

`ifdef SEQGEN_DEADTIME_EN
  // Blanking after each step, then reset asserted inside the blanking window.
  task automatic test_deadtime();
    int ei[11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 2};
    bit bz[11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
    exp_t e, o;
    div = 8'd4; dead = 4'd2; mode = 1'b0; dir = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 11) begin
        clr = 1'b0;
        #2;
        clr = 1'b1;
      end
      load = (c == 0); load_idx = 2'd0; en = (c != 0);
      if (c < 11) begin
        e = mk(4, ei[c], c == 5 || c == 10, 0);
        if (bz[c]) e.out = '0;
      end else begin
        e = mk(4, 0, 0, 0);
      end
      sb4.push_back(e);
      if (c == 11) begin
        e = sb4.pop_front();
        o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      end else begin
        clk_edge();
        e = sb4.pop_front();
        o = {1'b0, idx4, 1'b0, out4, tick4, wrap4};
      end
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL deadtime c=%0d dut4: got idx=%0d out=%b tick=%b wrap=%b, expected idx=%0d out=%b tick=%b wrap=%b",
                 c, o.idx, o.out, o.tick, o.wrap, e.idx, e.out, e.tick, e.wrap);
      end
    end
    load = 1'b0; en = 1'b0; dead = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_ring_up();
    test_ring_down_div();
    test_pingpong();
    test_en_hold();
    test_load();
    test_random();
`ifdef SEQGEN_DEADTIME_EN
    test_deadtime();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
